// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit for the EXE stage: one radix-2 step per
// cycle over operand magnitudes, then a single sign-fix cycle before HI/LO update.
module muldiv_unit #(
  parameter logic [31:0] DIV0_QUOT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  oper,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        whi,
  input  logic        wlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        accept;
  logic [31:0] a_in_mag, b_mag;
  logic        neg_a, neg_b, is_div;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next;
  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !cancel;

  // oper[0]=0 selects the signed flavour (MULT / DIV)
  assign a_in_mag = (!oper[0] && a[31]) ? -a : a;
  assign is_div   = op_q[1];
  assign neg_a    = !op_q[0] && a_q[31];
  assign neg_b    = !op_q[0] && b_q[31];
  assign b_mag    = neg_b ? -b_q : b_q;

  // Shift-add: acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
  assign div_sh   = acc_q[63:31];
  assign div_diff = {1'b0, div_sh} - {2'b00, b_mag};
  assign div_next = div_diff[33] ? {acc_q[62:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign prod_fix = (neg_a ^ neg_b) ? -acc_q : acc_q;
  assign quot_fix = (neg_a ^ neg_b) ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = neg_a ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_CALC;
          op_d    = oper;
          a_d     = a;
          b_d     = b;
          acc_d   = {32'd0, a_in_mag};
          cnt_d   = 5'd0;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div ? div_next : mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (!is_div) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = DIV0_QUOT;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // MTHI/MTLO lose to an accepted start so a new op never sees a half-written pair
    if (!busy && !accept) begin
      if (whi) hi_d = wdata;
      if (wlo) lo_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random operations against an
// arithmetic reference model; checks exact 34-cycle timing, cancel, reset and MTHI/MTLO.
module tb_muldiv_unit;

  localparam logic [31:0] DIV0_Q = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cancel, whi, wlo;
  logic [1:0]  oper;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur_hi, cur_lo;

  muldiv_unit #(.DIV0_QUOT(DIV0_Q)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .a(a), .b(b),
    .cancel(cancel), .whi(whi), .wlo(wlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      2'b00: begin sp = sx * sy; return sp; end
      2'b01: begin up = {32'd0, x} * {32'd0, y}; return up; end
      2'b10: begin
        if (y == 0) return {x, DIV0_Q};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 0) return {x, DIV0_Q};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Issue one op at the current negedge (cycle 0) and follow it to its done cycle.
  // inject: pulse a competing start and an MTHI write mid-operation.
  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, input string tag);
    logic [63:0] exp;
    bit ok;
    exp   = model(op, x, y);
    oper  = op; a = x; b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    oper  = 2'($urandom); a = $urandom; b = $urandom;
    ok = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== cur_hi || lo !== cur_lo) ok = 1'b0;
      if (inject && c == 5) begin
        start = 1'b1; oper = 2'($urandom); a = $urandom; b = $urandom;
        whi = 1'b1; wdata = $urandom;
      end
      tick();
      start = 1'b0; whi = 1'b0;
    end
    check({tag, "_busy_window"}, {31'd0, ok}, 32'd1);
    check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    cur_hi = exp[63:32];
    cur_lo = exp[31:0];
    tick();
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit ok;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; whi = 1'b0; wlo = 1'b0;
    oper = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
    cur_hi = 32'd0; cur_lo = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_flags", {30'd0, busy, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // Start presented at the same moment reset is released
    rst_n = 1'b1;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    check("multu_max_hi_lit", hi, 32'hFFFFFFFE);
    check("multu_max_lo_lit", lo, 32'h00000001);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, "mult_neg");
    check("mult_neg_lo_lit", lo, 32'hFFFFFFF1);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
    check("div_neg_lo_lit", lo, 32'hFFFFFFFD);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_small");
    run_op(2'b11, 32'd7, 32'd0, 1'b0, "divu_zero");
    check("divu_zero_hi_lit", hi, 32'd7);
    run_op(2'b10, 32'hFFFFFF00, 32'd0, 1'b0, "div_zero");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    check("div_ovf_lo_lit", lo, 32'h80000000);
    run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, "mult_minmin");
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, "div_pos_neg");

    // Competing start and MTHI while busy must not disturb the result
    run_op(2'b00, 32'h12345678, 32'hFEDCBA98, 1'b1, "inject");

    // Cancel in cycle 10 of a DIVU
    oper = 2'b11; a = 32'hDEADBEEF; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (done !== 1'b0 || busy !== 1'b0 || hi !== cur_hi || lo !== cur_lo) ok = 1'b0;
      tick();
    end
    check("cancel_quiet", {31'd0, ok}, 32'd1);

    // MTLO / MTHI while idle; then MTHI alongside an accepted start is dropped
    wlo = 1'b1; wdata = 32'hA5A5A5A5;
    tick();
    wlo = 1'b0;
    check("mtlo_lo", lo, 32'hA5A5A5A5);
    check("mtlo_hi_kept", hi, cur_hi);
    cur_lo = 32'hA5A5A5A5;
    whi = 1'b1; wdata = 32'h0BADF00D;
    run_op(2'b01, 32'd3, 32'd4, 1'b0, "mthi_vs_start");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_op(2'($urandom), ra, rb, 1'b0, "rand");
    end

    // Reset in cycle 20 of a MULT
    oper = 2'b00; a = 32'h7FFFFFFF; b = 32'h00010001; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {30'd0, busy, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    cur_hi = 32'd0; cur_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    whi = 1'b1; wdata = 32'h12345678;
    tick();
    whi = 1'b0;
    check("mthi_after_rst", hi, 32'h12345678);
    check("mthi_lo_kept", lo, 32'd0);
    cur_hi = 32'h12345678;
    run_op(2'b11, 32'hFFFFFFFF, 32'h10000, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
